// File: rtl/execute_muldiv_stage.sv
// RV64M execute-stage unit: iterative shift-add multiplier and restoring divider
// feeding a registered execute->memory pipeline slot.
module execute_muldiv_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5,
  parameter int ITER       = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_valid,
  input  logic [2:0]            i_func3,
  input  logic                  i_word,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_reg_we,
  input  logic [2:0]            i_result_src,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic                  o_reg_we,
  output logic [2:0]            o_result_src
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg_if_wide(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [W-1:0] word_fix(input logic [W-1:0] v, input logic w);
    return w ? {{(W-32){v[31]}}, v[31:0]} : v;
  endfunction

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            func3_p0;
  logic                  word_p0;
  logic [REG_ADDR_W-1:0] rd_addr_p0;
  logic                  reg_we_p0;
  logic [2:0]            result_src_p0;
  logic [W-1:0]          mag_a, mag_b;
  logic                  neg_res, neg_rem;
  logic [2*W-1:0]        prod;
  logic [W-1:0]          quot, rem;

  logic                  sgn_a, sgn_b, neg_a, neg_b;
  logic signed [W-1:0]   ext_a, ext_b;
  logic [W-1:0]          min_val, mag_a_c, mag_b_c;
  logic                  div_zero, div_ovf, fast;
  logic [W:0]            mul_sum;
  logic [W+1:0]          div_diff;
  logic                  div_ge;
  logic [2*W-1:0]        prod_fix;
  logic [W-1:0]          sel_res;

  // Operand preparation: width extension, magnitudes and fast-path detection
  always_comb begin
    unique case (i_func3)
      3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      3'b010:                         begin sgn_a = 1'b1; sgn_b = 1'b0; end
      default:                        begin sgn_a = 1'b0; sgn_b = 1'b0; end
    endcase
    ext_a    = i_word ? {{(W-32){sgn_a & i_src_a[31]}}, i_src_a[31:0]} : i_src_a;
    ext_b    = i_word ? {{(W-32){sgn_b & i_src_b[31]}}, i_src_b[31:0]} : i_src_b;
    neg_a    = sgn_a & ext_a[W-1];
    neg_b    = sgn_b & ext_b[W-1];
    mag_a_c  = neg_if($unsigned(ext_a), neg_a);
    mag_b_c  = neg_if($unsigned(ext_b), neg_b);
    min_val  = i_word ? {{(W-31){1'b1}}, 31'b0} : {1'b1, {(W-1){1'b0}}};
    div_zero = (ext_b == '0);
    div_ovf  = sgn_a & ($unsigned(ext_a) == min_val) & (ext_b == '1);
    fast     = i_func3[2] & (div_zero | div_ovf);
  end

  // One iteration of each algorithm, consumed in CALC
  always_comb begin
    mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
    div_diff = {1'b0, rem, quot[W-1]} - {2'b00, mag_b};
    div_ge   = ~div_diff[W+1];
  end

  // Sign correction and result selection, consumed in DONE
  always_comb begin
    prod_fix = neg_if_wide(prod, neg_res);
    unique case (func3_p0)
      3'b000:                 sel_res = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: sel_res = prod_fix[2*W-1:W];
      3'b100, 3'b101:         sel_res = neg_if(quot, neg_res);
      default:                sel_res = neg_if(rem, neg_rem);
    endcase
  end

  assign o_busy = ~i_flush & (((state == IDLE) & i_valid) | (state == CALC));

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state         <= IDLE;
      cnt           <= '0;
      func3_p0      <= '0;
      word_p0       <= 1'b0;
      rd_addr_p0    <= '0;
      reg_we_p0     <= 1'b0;
      result_src_p0 <= '0;
      mag_a         <= '0;
      mag_b         <= '0;
      neg_res       <= 1'b0;
      neg_rem       <= 1'b0;
      prod          <= '0;
      quot          <= '0;
      rem           <= '0;
      o_valid       <= 1'b0;
      o_alu_result  <= '0;
      o_rd_addr     <= '0;
      o_reg_we      <= 1'b0;
      o_result_src  <= '0;
    end else begin
      o_valid  <= 1'b0;
      o_reg_we <= 1'b0;
      if (i_flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (i_valid) begin
            func3_p0      <= i_func3;
            word_p0       <= i_word;
            rd_addr_p0    <= i_rd_addr;
            reg_we_p0     <= i_reg_we;
            result_src_p0 <= i_result_src;
            mag_a         <= mag_a_c;
            mag_b         <= mag_b_c;
            cnt           <= '0;
            if (fast) begin
              // Final values stored unsigned-corrected so DONE passes them through
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              quot    <= div_zero ? '1 : $unsigned(ext_a);
              rem     <= div_zero ? $unsigned(ext_a) : '0;
              state   <= DONE;
            end else begin
              neg_res <= neg_a ^ neg_b;
              neg_rem <= neg_a;
              quot    <= mag_a_c;
              rem     <= '0;
              prod    <= {{W{1'b0}}, mag_b_c};
              state   <= CALC;
            end
          end
          CALC: begin
            if (func3_p0[2]) begin
              rem  <= div_ge ? div_diff[W-1:0] : {rem[W-2:0], quot[W-1]};
              quot <= {quot[W-2:0], div_ge};
            end else begin
              prod <= {mul_sum, prod[W-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(ITER - 1)) state <= DONE;
          end
          DONE: begin
            o_alu_result <= word_fix(sel_res, word_p0);
            o_rd_addr    <= rd_addr_p0;
            o_result_src <= result_src_p0;
            o_reg_we     <= reg_we_p0;
            o_valid      <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Self-checking bench for execute_muldiv_stage: directed vector table, multi-cycle
// corner sequences (back-to-back, flush, async reset) and randomized ops vs a model.
module tb_execute_muldiv_stage;

  logic        i_clk = 1'b0;
  logic        i_arst = 1'b0;
  logic        i_valid = 1'b0;
  logic [2:0]  i_func3 = '0;
  logic        i_word = 1'b0;
  logic [63:0] i_src_a = '0;
  logic [63:0] i_src_b = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        i_reg_we = 1'b0;
  logic [2:0]  i_result_src = '0;
  logic        i_flush = 1'b0;
  logic        o_busy, o_valid, o_reg_we;
  logic [63:0] o_alu_result;
  logic [4:0]  o_rd_addr;
  logic [2:0]  o_result_src;

  execute_muldiv_stage #(.DATA_WIDTH(64), .REG_ADDR_W(5), .ITER(64)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_valid(i_valid), .i_func3(i_func3),
    .i_word(i_word), .i_src_a(i_src_a), .i_src_b(i_src_b), .i_rd_addr(i_rd_addr),
    .i_reg_we(i_reg_we), .i_result_src(i_result_src), .i_flush(i_flush),
    .o_busy(o_busy), .o_valid(o_valid), .o_alu_result(o_alu_result),
    .o_rd_addr(o_rd_addr), .o_reg_we(o_reg_we), .o_result_src(o_result_src)
  );

  always #5 i_clk = ~i_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] last_res = '0;
  logic [4:0]  last_rd = '0;
  logic [2:0]  last_rs = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (architectural arithmetic) ----------------
  function automatic logic sgn_a_of(input logic [2:0] f);
    return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
  endfunction
  function automatic logic sgn_b_of(input logic [2:0] f);
    return f inside {3'd0, 3'd1, 3'd4, 3'd6};
  endfunction
  function automatic logic [63:0] ext_of(input logic [63:0] v, input logic w, input logic s);
    if (!w) return v;
    return s ? {{32{v[31]}}, v[31:0]} : {32'h0, v[31:0]};
  endfunction
  function automatic logic is_fast(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea, eb, minv;
    ea   = ext_of(a, w, sgn_a_of(f));
    eb   = ext_of(b, w, sgn_b_of(f));
    minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    return f[2] && (eb == 64'd0 || (sgn_a_of(f) && ea == minv && eb == '1));
  endfunction
  function automatic logic [63:0] model(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea, eb, q, r, res, minv;
    logic [127:0] pa, pb, p;
    logic signed [63:0] sea, seb;
    logic sa, sb;
    sa = sgn_a_of(f);
    sb = sgn_b_of(f);
    ea = ext_of(a, w, sa);
    eb = ext_of(b, w, sb);
    pa = sa ? {{64{ea[63]}}, ea} : {64'h0, ea};
    pb = sb ? {{64{eb[63]}}, eb} : {64'h0, eb};
    p  = pa * pb;
    minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (eb == 64'd0) begin
      q = '1; r = ea;
    end else if (sa && ea == minv && eb == '1) begin
      q = ea; r = 64'd0;
    end else if (sa) begin
      sea = ea; seb = eb;
      q = sea / seb; r = sea % seb;
    end else begin
      q = ea / eb; r = ea % eb;
    end
    case (f)
      3'd0:             res = p[63:0];
      3'd1, 3'd2, 3'd3: res = p[127:64];
      3'd4, 3'd5:       res = q;
      default:          res = r;
    endcase
    if (w) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  // Issue one op at the current (post-edge) time and follow it to completion
  task automatic run_op(input string name, input logic [2:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic we, input logic [2:0] rs, input logic [63:0] exp,
                        input int exp_lat);
    int lat, busy_n;
    i_func3 = f; i_word = w; i_src_a = a; i_src_b = b;
    i_rd_addr = rd; i_reg_we = we; i_result_src = rs; i_valid = 1'b1;
    #1;
    check({name, " busy_at_accept"}, 64'(o_busy), 64'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 0; busy_n = 0;
    while (!o_valid && lat < 200) begin
      if (o_busy) busy_n++;
      @(posedge i_clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    if (o_valid) begin
      check({name, " result"}, o_alu_result, exp);
      check({name, " reg_we"}, 64'(o_reg_we), 64'(we));
      check({name, " rd_addr"}, 64'(o_rd_addr), 64'(rd));
      check({name, " result_src"}, 64'(o_result_src), 64'(rs));
      last_res = exp; last_rd = rd; last_rs = rs;
    end
    @(posedge i_clk); #1;
    check({name, " valid_pulse"}, 64'(o_valid), 64'd0);
    check({name, " bubble_we"}, 64'(o_reg_we), 64'd0);
    check({name, " hold_result"}, o_alu_result, last_res);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic        w;
    logic [63:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_8000_0000;
      4:       return 64'($urandom_range(0, 20));
      5:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int flush_valids;
    vecs[0]  = '{"mul_7x-3",      3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{"mulhu_max_x2",  3'd3, 1'b0, '1, 64'd2, 64'd1, 65};
    vecs[2]  = '{"mulhsu_-1_x2",  3'd2, 1'b0, '1, 64'd2, '1, 65};
    vecs[3]  = '{"div_-7_2",      3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[4]  = '{"rem_-7_2",      3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65};
    vecs[5]  = '{"divu_100_7",    3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[6]  = '{"remu_100_7",    3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vecs[7]  = '{"divu_5_0",      3'd5, 1'b0, 64'd5, 64'd0, '1, 1};
    vecs[8]  = '{"rem_5_0",       3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[9]  = '{"div_ovf",       3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    vecs[10] = '{"rem_ovf",       3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
    vecs[11] = '{"divw_ovf",      3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[12] = '{"mulw_7fff_x2",  3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[13] = '{"mulh_-1_x-1",   3'd1, 1'b0, '1, '1, 64'd0, 65};
    vecs[14] = '{"mulh_min_min",  3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65};

    // Reset state
    #12;
    check("rst valid", 64'(o_valid), 64'd0);
    check("rst result", o_alu_result, 64'd0);
    check("rst rd_addr", 64'(o_rd_addr), 64'd0);
    check("rst reg_we", 64'(o_reg_we), 64'd0);
    check("rst result_src", 64'(o_result_src), 64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    @(negedge i_clk); i_arst = 1'b1;
    @(posedge i_clk); #1;

    // Directed vector table
    for (int i = 0; i < 15; i++)
      run_op(vecs[i].name, vecs[i].f, vecs[i].w, vecs[i].a, vecs[i].b, 5'(i + 1),
             1'(i % 2 == 0), 3'(i), vecs[i].exp, vecs[i].lat);

    // Back-to-back: second op presented in the IDLE cycle right after DONE
    i_func3 = 3'd5; i_word = 1'b0; i_src_a = 64'd5; i_src_b = 64'd0;
    i_rd_addr = 5'd3; i_reg_we = 1'b1; i_result_src = 3'd1; i_valid = 1'b1;
    @(posedge i_clk); #1; i_valid = 1'b0;
    @(posedge i_clk); #1;
    check("b2b first valid", 64'(o_valid), 64'd1);
    check("b2b first result", o_alu_result, '1);
    i_func3 = 3'd7; i_src_a = 64'd9; i_src_b = 64'd0; i_rd_addr = 5'd4; i_valid = 1'b1;
    #1;
    check("b2b second busy", 64'(o_busy), 64'd1);
    @(posedge i_clk); #1; i_valid = 1'b0;
    check("b2b gap valid", 64'(o_valid), 64'd0);
    @(posedge i_clk); #1;
    check("b2b second valid", 64'(o_valid), 64'd1);
    check("b2b second result", o_alu_result, 64'd9);
    check("b2b second rd", 64'(o_rd_addr), 64'd4);
    last_res = 64'd9; last_rd = 5'd4; last_rs = 3'd1;
    @(posedge i_clk); #1;

    // Flush at counter 30
    i_func3 = 3'd0; i_word = 1'b0; i_src_a = 64'd3; i_src_b = 64'd5;
    i_rd_addr = 5'd9; i_reg_we = 1'b1; i_result_src = 3'd2; i_valid = 1'b1;
    @(posedge i_clk); #1; i_valid = 1'b0;
    repeat (30) begin @(posedge i_clk); #1; end
    check("flush pre busy", 64'(o_busy), 64'd1);
    i_flush = 1'b1;
    #1;
    check("flush busy", 64'(o_busy), 64'd0);
    @(posedge i_clk); #1; i_flush = 1'b0;
    check("flush valid", 64'(o_valid), 64'd0);
    check("flush reg_we", 64'(o_reg_we), 64'd0);
    check("flush idle busy", 64'(o_busy), 64'd0);
    flush_valids = 0;
    repeat (80) begin
      @(posedge i_clk); #1;
      if (o_valid || o_reg_we) flush_valids++;
    end
    check("flush no completion", 64'(flush_valids), 64'd0);
    check("flush hold result", o_alu_result, last_res);
    check("flush hold rd", 64'(o_rd_addr), 64'(last_rd));
    check("flush hold src", 64'(o_result_src), 64'(last_rs));

    // Async reset mid-CALC, then a fresh op
    i_func3 = 3'd0; i_src_a = 64'd11; i_src_b = 64'd13; i_rd_addr = 5'd17; i_valid = 1'b1;
    @(posedge i_clk); #1; i_valid = 1'b0;
    repeat (20) begin @(posedge i_clk); #1; end
    i_arst = 1'b0;
    #1;
    check("arst result", o_alu_result, 64'd0);
    check("arst rd", 64'(o_rd_addr), 64'd0);
    check("arst src", 64'(o_result_src), 64'd0);
    check("arst valid", 64'(o_valid), 64'd0);
    check("arst busy", 64'(o_busy), 64'd0);
    @(negedge i_clk); i_arst = 1'b1;
    @(posedge i_clk); #1;
    last_res = 64'd0;
    run_op("post_arst_mul", 3'd0, 1'b0, 64'd11, 64'd13, 5'd17, 1'b1, 3'd5, 64'd143, 65);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic        w;
      logic [63:0] a, b;
      f = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = rnd_operand();
      b = rnd_operand();
      run_op($sformatf("rnd%0d_f%0d_w%0d", i, f, w), f, w, a, b, 5'($urandom),
             1'($urandom), 3'($urandom), model(f, w, a, b), is_fast(f, w, a, b) ? 1 : 65);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_stage.md
Name: execute_muldiv_stage

Overview:
- Execute-stage M-extension unit (RV64M incl. W variants) with its own execute→memory pipeline register; sits directly upstream of the memory stage and drives its alu_result, rd_addr, reg_we and result_src inputs.
- Iterative shift-add multiplier and restoring divider, one bit per cycle; stalls the front end via o_busy while computing and injects a bubble when idle.

Parameters:
DATA_WIDTH, 64, operand/result width
REG_ADDR_W, 5, register address width
ITER, 64, iterations per multi-cycle op (= DATA_WIDTH)

Ports:
i_clk  in  1  clock, rising edge
i_arst  in  1  asynchronous reset, active-low
i_valid  in  1  M-op presented this cycle
i_func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_word  in  1  1 = *W variant (32-bit operands, sign-extended 32-bit result)
i_src_a  in  DATA_WIDTH  rs1 value
i_src_b  in  DATA_WIDTH  rs2 value
i_rd_addr  in  REG_ADDR_W  destination register
i_reg_we  in  1  writeback enable of the op
i_result_src  in  3  writeback select, passed through
i_flush  in  1  synchronous abort
o_busy  out  1  stall request to upstream stages (combinational)
o_valid  out  1  output register holds a completed op (registered)
o_alu_result  out  DATA_WIDTH  result to memory stage (registered)
o_rd_addr  out  REG_ADDR_W  registered
o_reg_we  out  1  registered; 0 for bubbles
o_result_src  out  3  registered

Behaviour:
- Reset (i_arst low, async): state IDLE, counter 0, all internal registers 0; o_valid 0, o_alu_result 0, o_rd_addr 0, o_reg_we 0, o_result_src 0. Reset mid-operation discards the op.
- FSM states: IDLE, CALC, DONE.
- IDLE: on i_valid & !i_flush, latch func3, word, rd_addr, reg_we, result_src; latch operand magnitudes and result sign. Go to DONE if fast path, else CALC with counter 0.
- Operand prep: when i_word, use bits [31:0] of each operand, sign-extended (signed ops) or zero-extended (unsigned ops) to 64 bits. Signedness: MUL/MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU both unsigned.
- Fast path (skips CALC): divisor == 0 → quotient all ones, remainder = dividend; signed overflow (dividend = most negative, divisor = -1, per operand width) → quotient = dividend, remainder 0.
- CALC: one iteration per edge. Multiply: 128-bit shift-add of magnitudes. Divide: restoring, one quotient bit per edge. Counter increments; after the iteration with counter == ITER-1, go to DONE.
- DONE (one cycle): apply sign correction (two's-complement negate product/quotient if result sign set; remainder takes dividend sign). Select MUL = product[63:0], MULH* = product[127:64], DIV* = quotient, REM* = remainder. If word, sign-extend bits [31:0]. Load output register; o_valid and o_reg_we (= latched reg_we) go 1; return to IDLE.
- Output register in any cycle not ending in DONE: bubble. o_valid 0, o_reg_we 0; o_alu_result, o_rd_addr and o_result_src hold their values.
- o_busy = (IDLE & i_valid & !i_flush) | CALC. It is low in DONE, so upstream advances on the DONE edge.
- Latency: accept edge E0, CALC edges E1..E64, DONE edge E65; o_valid high in the cycle after E65, for exactly one cycle. Fast path: o_valid high after E1.
- i_flush (sync, priority over everything): any state → IDLE; no output register load (bubble); o_busy low that cycle.
- Back-to-back: a new i_valid is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- MUL 7 × -3 (64-bit) → o_valid pulses one cycle after E65; o_alu_result = 0xFFFF_FFFF_FFFF_FFEB, o_reg_we 1, o_rd_addr echoes input; o_busy high from accept cycle through E64.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 → 0x0000_0000_0000_0001; MULHSU -1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV -7 / 2 → -3 (0xFFFF_FFFF_FFFF_FFFD); REM -7 / 2 → -1; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → all ones; REM 5 / 0 → 5; DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000, REM → 0. All via fast path, o_valid after E1, no CALC.
- DIVW with i_word = 1, a = 0x0000_0000_8000_0000, b = 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_8000_0000 (overflow); MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
- i_flush at counter 30 → IDLE next cycle, o_valid/o_reg_we stay 0, o_busy low. Separately, i_arst low mid-CALC → all outputs 0 immediately; next op after release completes correctly.
